// File: rtl/f5_scan_pkg.sv
// Shared definitions for the f5 truth-table scan sequencer: FSM state
// encodings, minterm count and derived widths.
package f5_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_e;

  localparam int NUM_MINTERMS = 4;
  localparam int MINTERM_W    = $clog2(NUM_MINTERMS);
  localparam int CNT_W        = 4;

endpackage

// File: rtl/f5_scan_settle_counter.sv
// Settle-time counter: counts cycles while enabled and flags the cycle in
// which SETTLE-1 has been reached, so the sequencer knows the operands have
// been stable long enough to sample.
module settle_counter
  import f5_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  // Clear has priority over counting so a new minterm always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/f5_scan_sequencer.sv
// Walks the two-input minterms 00,01,10,11 through two f5 implementations,
// holds each operand pair for SETTLE cycles, samples both results into
// truth tables and flags any disagreement when the scan completes.
module f5_scan_sequencer
  import f5_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    res_a,
  input  logic                    res_b,
  output logic                    x,
  output logic                    y,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_MINTERMS-1:0] table_a,
  output logic [NUM_MINTERMS-1:0] table_b,
  output logic                    mismatch
);

  scan_state_e             state, state_nxt;
  logic [MINTERM_W-1:0]    m, m_nxt;
  logic [NUM_MINTERMS-1:0] ta_nxt, tb_nxt;
  logic                    mm_nxt;
  logic                    cnt_clr, cnt_en, cnt_tc;

  settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  // Next-state, minterm advance, table capture and counter control.
  always_comb begin
    state_nxt = state;
    m_nxt     = m;
    ta_nxt    = table_a;
    tb_nxt    = table_b;
    mm_nxt    = mismatch;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SETTLE;
          m_nxt     = '0;
          ta_nxt    = '0;
          tb_nxt    = '0;
          mm_nxt    = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      ST_SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        ta_nxt[m] = res_a;
        tb_nxt[m] = res_b;
        cnt_clr   = 1'b1;
        if (m == MINTERM_W'(NUM_MINTERMS - 1)) begin
          state_nxt = ST_DONE;
          // Compare the completed tables (including the bit captured on this
          // edge) so mismatch is already valid while done is high.
          mm_nxt    = |(ta_nxt ^ tb_nxt);
        end else begin
          state_nxt = ST_SETTLE;
          m_nxt     = m + MINTERM_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, minterm index and result registers; all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      m        <= '0;
      table_a  <= '0;
      table_b  <= '0;
      mismatch <= 1'b0;
    end else begin
      state    <= state_nxt;
      m        <= m_nxt;
      table_a  <= ta_nxt;
      table_b  <= tb_nxt;
      mismatch <= mm_nxt;
    end
  end

  assign x    = m[1];
  assign y    = m[0];
  assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_f5_scan_sequencer.sv
// Bench for f5_scan_sequencer: two instances (SETTLE=1 and SETTLE=3) share
// clock, reset and start; each is fed by an f5 model with optional per-minterm
// fault masks and compared every cycle against a timeline model of the scan.
module tb_f5_scan_sequencer;

  localparam int S1 = 1;
  localparam int S3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic cmp_en = 1'b0;
  logic [3:0] mask_a = 4'b0000;
  logic [3:0] mask_b = 4'b0000;

  always #5 clk = ~clk;

  logic x1, y1, busy1, done1, mm1, ra1, rb1;
  logic [3:0] ta1, tb1;
  logic x3, y3, busy3, done3, mm3, ra3, rb3;
  logic [3:0] ta3, tb3;

  function automatic logic f5(input logic a, input logic b);
    return a | ~b;
  endfunction

  assign ra1 = f5(x1, y1) ^ mask_a[{x1, y1}];
  assign rb1 = f5(x1, y1) ^ mask_b[{x1, y1}];
  assign ra3 = f5(x3, y3) ^ mask_a[{x3, y3}];
  assign rb3 = f5(x3, y3) ^ mask_b[{x3, y3}];

  f5_scan_sequencer #(.SETTLE(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .res_a(ra1), .res_b(rb1),
    .x(x1), .y(y1), .busy(busy1), .done(done1),
    .table_a(ta1), .table_b(tb1), .mismatch(mm1)
  );

  f5_scan_sequencer #(.SETTLE(S3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .res_a(ra3), .res_b(rb3),
    .x(x3), .y(y3), .busy(busy3), .done(done3),
    .table_a(ta3), .table_b(tb3), .mismatch(mm3)
  );

  logic [12:0] act0, act1;
  assign act0 = {x1, y1, busy1, done1, ta1, tb1, mm1};
  assign act1 = {x3, y3, busy3, done3, ta3, tb3, mm3};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: ph = cycles since the accepting edge, -1 when idle.
  int         ph[2];
  logic [1:0] lm[2];
  logic [3:0] hta[2], htb[2];
  logic       hmm[2];

  function automatic int sval(input int i);
    return (i == 0) ? S1 : S3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        ph[i]  <= -1;
        lm[i]  <= 2'd0;
        hta[i] <= 4'd0;
        htb[i] <= 4'd0;
        hmm[i] <= 1'b0;
      end else if (ph[i] < 0) begin
        if (start) ph[i] <= 0;
      end else if (ph[i] == 4 * (sval(i) + 1)) begin
        ph[i]  <= -1;
        lm[i]  <= 2'd3;
        hta[i] <= 4'b1101 ^ mask_a;
        htb[i] <= 4'b1101 ^ mask_b;
        hmm[i] <= |(mask_a ^ mask_b);
      end else begin
        ph[i] <= ph[i] + 1;
      end
    end
  end

  function automatic logic [12:0] expect_vec(input int i);
    int s, j;
    logic [3:0] fa, fb, msk;
    s  = sval(i);
    fa = 4'b1101 ^ mask_a;
    fb = 4'b1101 ^ mask_b;
    if (ph[i] < 0) return {lm[i][1], lm[i][0], 2'b00, hta[i], htb[i], hmm[i]};
    if (ph[i] == 4 * (s + 1)) return {2'b11, 2'b01, fa, fb, |(fa ^ fb)};
    j   = ph[i] / (s + 1);
    msk = 4'((1 << j) - 1);
    return {j[1], j[0], 2'b10, fa & msk, fb & msk, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("out_s1", {19'd0, act0}, {19'd0, expect_vec(0)});
      check("out_s3", {19'd0, act1}, {19'd0, expect_vec(1)});
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy1 | done1 | busy3 | done3) && n < 200);
    if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done1();
    int n;
    n = 0;
    while (!done1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done1_seen", {31'd0, done1}, 32'd1);
  endtask

  initial begin
    int c, dn;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s1", {19'd0, act0}, 32'd0);
    check("rst_s3", {19'd0, act1}, 32'd0);
    cmp_en = 1'b1;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);

    // Correct implementations, literal x/y sequence and done latency.
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("xy_seq_s1", {30'd0, x1, y1}, 32'(k / 2));
      check("busy_seq_s1", {31'd0, busy1}, 32'd1);
    end
    @(negedge clk);
    check("done_cyc8_s1", {31'd0, done1}, 32'd1);
    check("table_a_ok", {28'd0, ta1}, 32'b1101);
    check("table_b_ok", {28'd0, tb1}, 32'b1101);
    check("mismatch_ok", {31'd0, mm1}, 32'd0);
    c = 8;
    while (!done3 && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("done_cyc16_s3", 32'(c), 32'd16);
    wait_idle();

    // res_b stuck at 1: minterm 1 disagrees.
    mask_b = 4'b0010;
    pulse_start();
    wait_done1();
    check("stuck_table_a", {28'd0, ta1}, 32'b1101);
    check("stuck_table_b", {28'd0, tb1}, 32'b1111);
    check("stuck_mismatch", {31'd0, mm1}, 32'd1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("mismatch_hold", {31'd0, mm1}, 32'd1);

    // Rescan with correct results: tables and mismatch cleared at acceptance.
    mask_b = 4'b0000;
    pulse_start();
    check("clear_mm", {31'd0, mm1}, 32'd0);
    check("clear_tables", {24'd0, ta1, tb1}, 32'd0);
    wait_done1();
    check("rescan_mm", {31'd0, mm1}, 32'd0);
    wait_idle();

    // Start held high: one done, restart only from the IDLE cycle after DONE.
    @(negedge clk);
    start = 1'b1;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done1) dn++;
      if (k == 9) check("held_idle_gap", {30'd0, busy1, done1}, 32'd0);
      if (k == 10) check("held_restart", {29'd0, busy1, x1, y1}, 32'b100);
    end
    start = 1'b0;
    check("held_one_done", 32'(dn), 32'd1);
    wait_idle();

    // Randomized fault masks and start activity, including starts while busy.
    for (int it = 0; it < 15; it++) begin
      mask_a = 4'($urandom_range(0, 15));
      mask_b = 4'($urandom_range(0, 15));
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        start = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      start = 1'b0;
      wait_idle();
    end

    // Asynchronous reset during SAMPLE of minterm 2.
    mask_a = 4'b0000;
    mask_b = 4'b0000;
    pulse_start();
    c = 0;
    while (ph[0] != 5 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("pre_rst_state", {29'd0, busy1, x1, y1}, 32'b110);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_s1", {19'd0, act0}, 32'd0);
    check("async_rst_s3", {19'd0, act1}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_after_rst", {30'd0, busy1, busy3}, 32'd0);
    end
    pulse_start();
    wait_done1();
    check("post_rst_table", {24'd0, ta1, tb1}, {24'd0, 8'b1101_1101});
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/f5_scan_sequencer.md
F5_SCAN_SEQUENCER -- requirements
Module: f5_scan_sequencer

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning the number of clock cycles operands are held stable before the result is sampled; legal range is 1..15.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, scan request, sampled in IDLE only.
REQ-005 SHALL have port res_a, input, 1 bit, result from the gate-level f5 implementation.
REQ-006 SHALL have port res_b, input, 1 bit, result from the expression-level f5 implementation.
REQ-007 SHALL have port x, output, 1 bit, operand a driven to both implementations; equals minterm index bit 1.
REQ-008 SHALL have port y, output, 1 bit, operand b driven to both implementations; equals minterm index bit 0.
REQ-009 SHALL have port busy, output, 1 bit, high in SETTLE and SAMPLE states.
REQ-010 SHALL have port done, output, 1 bit, single-cycle completion pulse.
REQ-011 SHALL have port table_a, output, 4 bits, captured truth table of res_a; bit m holds the result for minterm m.
REQ-012 SHALL have port table_b, output, 4 bits, captured truth table of res_b, indexed the same way.
REQ-013 SHALL have port mismatch, output, 1 bit, high when table_a differs from table_b.

Function
REQ-014 SHALL implement an FSM with states IDLE, SETTLE, SAMPLE and DONE, plus a 2-bit minterm index m and a 4-bit settle counter cnt.
REQ-015 SHALL, in IDLE with start=1 at an edge, clear table_a, table_b and mismatch, set m=0 and cnt=0, and enter SETTLE.
REQ-016 SHALL, in IDLE with start=0, remain in IDLE and hold all outputs.
REQ-017 SHALL drive x=m[1] and y=m[0] combinationally from m in every state; x and y SHALL be 0 in IDLE after reset.
REQ-018 SHALL, in SETTLE, increment cnt each cycle and enter SAMPLE on the edge where cnt==SETTLE-1.
REQ-019 SHALL, in SAMPLE, write res_a into table_a[m] and res_b into table_b[m] on the leaving edge.
REQ-020 SHALL, on leaving SAMPLE with m==3, go to DONE; otherwise it SHALL increment m, clear cnt and go to SETTLE.
REQ-021 SHALL spend SETTLE+1 cycles per minterm, so done is high in the cycle starting 4*(SETTLE+1) edges after the start-accepting edge.
REQ-022 SHALL, in DONE, hold done=1 for exactly one cycle, register mismatch = OR-reduce(table_a XOR table_b), and return to IDLE.
REQ-023 SHALL hold table_a, table_b and mismatch stable from DONE until the next accepted start.
REQ-024 SHALL ignore start while busy or in DONE, with no restart and no queuing.
REQ-025 SHALL let m wrap 3 to 0 only through IDLE, never directly.

Reset
REQ-026 SHALL, on rst_n=0 asynchronously and in any state including mid-scan, force IDLE, m=0, cnt=0, x=0, y=0, busy=0, done=0, table_a=0, table_b=0 and mismatch=0.
REQ-027 SHALL resume normal operation from the first rising edge of clk after rst_n deasserts, requiring a fresh start.

Structure
REQ-028 SHALL take the state encodings (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3) and the constant NUM_MINTERMS=4 from a shared package, f5_scan_pkg.
REQ-029 SHALL place the settle counter in one sub-module, settle_counter (clear, enable, terminal-count output).
REQ-030 SHALL keep the FSM, the capture registers and the mismatch logic in f5_scan_sequencer itself.

Verification
REQ-031 SHALL cover: both implementations correct (s = a | ~b), SETTLE=1, start pulse -> x,y sequence 00,01,10,11, each held for 2 cycles; done high in the 8th cycle after acceptance; table_a=table_b=4'b1101; mismatch=0.
REQ-032 SHALL cover: res_b forced to 1 -> table_a=4'b1101, table_b=4'b1111, mismatch=1 at done.
REQ-033 SHALL cover: SETTLE=3 -> each minterm held for 4 cycles; done in the 16th cycle after acceptance.
REQ-034 SHALL cover: start held high through a scan -> exactly one done pulse; a new scan begins only at the IDLE edge after DONE.
REQ-035 SHALL cover: rst_n=0 asserted during SAMPLE of m=2 -> all outputs 0 immediately without waiting for a clock edge; FSM idle after release until a new start.
REQ-036 SHALL cover: a second scan after a mismatching scan -> tables cleared at acceptance and mismatch=0 when both implementations are correct.
